// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture unit: packs active writeback/memory cycles into cycle-stamped
// records held in a FIFO, with instruction/cycle counters and a run-length watchdog.
module cpu_trace_buffer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int REG_W    = 4,
    parameter int DEPTH    = 16,
    parameter int CYC_W    = 32,
    parameter int WATCHDOG = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              reg_we,
    input  logic [REG_W-1:0]  reg_dest,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              halt,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [3:0]        trc_flags,
    output logic [CYC_W-1:0]  trc_cycle,
    output logic [REG_W-1:0]  trc_dest,
    output logic [DATA_W-1:0] trc_rdata,
    output logic [ADDR_W-1:0] trc_addr,
    output logic [DATA_W-1:0] trc_mdata,
    output logic [CYC_W-1:0]  inst_count,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [15:0]       drop_count,
    output logic              overflow,
    output logic              halted,
    output logic              timeout,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CYC_W-1:0] WD_STAMP = CYC_W'(WATCHDOG);

    typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;
    state_t state, stateNext;

    logic [3:0]        flagMem  [DEPTH];
    logic [CYC_W-1:0]  cycMem   [DEPTH];
    logic [REG_W-1:0]  destMem  [DEPTH];
    logic [DATA_W-1:0] rdataMem [DEPTH];
    logic [ADDR_W-1:0] addrMem  [DEPTH];
    logic [DATA_W-1:0] mdataMem [DEPTH];

    logic [PTR_W:0]   wrPtr, rdPtr;
    logic [PTR_W-1:0] wrIdx, rdIdx;
    logic             empty, full, pop, push, drop;
    logic             inRun, recActive, instEvent, wdHit;
    logic [CYC_W-1:0] stamp;

    logic [3:0]        recFlags;
    logic [REG_W-1:0]  recDest;
    logic [DATA_W-1:0] recRdata;
    logic [ADDR_W-1:0] recAddr;
    logic [DATA_W-1:0] recMdata;

    assign wrIdx     = wrPtr[PTR_W-1:0];
    assign rdIdx     = rdPtr[PTR_W-1:0];
    assign empty     = (wrPtr == rdPtr);
    assign full      = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrIdx == rdIdx);
    assign trc_valid = !empty;
    assign pop       = trc_valid && trc_ready;

    always_comb begin
        stateNext = state;
        inRun     = (state == RUN);
        stamp     = (cycle_count == '1) ? cycle_count : cycle_count + CYC_W'(1);
        wdHit     = (WATCHDOG != 0) && (stamp == WD_STAMP) && !halt;

        recFlags  = inRun ? {halt, mem_wr, mem_rd, reg_we} : 4'b0000;
        recActive = |recFlags;
        recDest   = recFlags[0] ? reg_dest : '0;
        recRdata  = recFlags[0] ? reg_data : '0;
        recAddr   = (recFlags[1] || recFlags[2]) ? mem_addr : '0;
        recMdata  = recFlags[2] ? mem_wdata : (recFlags[1] ? mem_rdata : '0);
        instEvent = inRun && (halt || reg_we || mem_wr);

        // A full FIFO still accepts a record when the head leaves on the same edge.
        push = recActive && (!full || pop);
        drop = recActive && !push;

        case (state)
            IDLE:    if (enable) stateNext = RUN;
            RUN: begin
                if (halt)       stateNext = HALTED;
                else if (wdHit) stateNext = TIMEOUT;
            end
            default: stateNext = state;
        endcase
    end

    always_comb begin
        trc_flags = '0;
        trc_cycle = '0;
        trc_dest  = '0;
        trc_rdata = '0;
        trc_addr  = '0;
        trc_mdata = '0;
        if (trc_valid) begin
            trc_flags = flagMem[rdIdx];
            trc_cycle = cycMem[rdIdx];
            trc_dest  = destMem[rdIdx];
            trc_rdata = rdataMem[rdIdx];
            trc_addr  = addrMem[rdIdx];
            trc_mdata = mdataMem[rdIdx];
        end
    end

    assign halted  = (state == HALTED);
    assign timeout = (state == TIMEOUT);
    assign done    = (halted || timeout) && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= stateNext;
            if (push) wrPtr <= wrPtr + (PTR_W+1)'(1);
            if (pop)  rdPtr <= rdPtr + (PTR_W+1)'(1);
            if (inRun) cycle_count <= stamp;
            if (instEvent && inst_count != '1) inst_count <= inst_count + CYC_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            flagMem[wrIdx]  <= recFlags;
            cycMem[wrIdx]   <= stamp;
            destMem[wrIdx]  <= recDest;
            rdataMem[wrIdx] <= recRdata;
            addrMem[wrIdx]  <= recAddr;
            mdataMem[wrIdx] <= recMdata;
        end
    end

endmodule
